// File: rtl/handshake_eager_fork_buffered.sv
// handshake_eager_fork_buffered: one-slot registered token fanned out eagerly to SIZE consumers
module handshake_eager_fork_buffered #(
  parameter int DATA_TYPE = 32,
  parameter int SIZE = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DATA_TYPE-1:0]      ins,
  input  logic                      ins_valid,
  output logic                      ins_ready,
  output logic [SIZE*DATA_TYPE-1:0] outs,
  output logic [SIZE-1:0]           outs_valid,
  input  logic [SIZE-1:0]           outs_ready
);
  logic                 full;
  logic [DATA_TYPE-1:0] data_reg;
  logic [SIZE-1:0]      sent;
  logic                 done_now;
  logic                 accept;
  assign outs_valid = {SIZE{full}} & ~sent;
  assign outs       = {SIZE{data_reg}};
  assign done_now   = full & (&(sent | outs_ready));
  assign ins_ready  = ~rst & (~full | done_now);
  assign accept     = ins_valid & ins_ready;
  // A refill on the last pending transfer takes priority so streaming has no bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full     <= 1'b0;
      data_reg <= '0;
      sent     <= '0;
    end else if (accept) begin
      full     <= 1'b1;
      data_reg <= ins;
      sent     <= '0;
    end else if (done_now) begin
      full <= 1'b0;
      sent <= '0;
    end else begin
      sent <= sent | (outs_valid & outs_ready);
    end
  end
endmodule
